// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared op codes, sequencer states and JK next-state helper
package jk_bank_pkg;
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_RESP} state_t;

    function automatic logic jk_next(input logic q, input logic [1:0] op);
        return op == JK_TGL ? ~q : op == JK_SET ? 1'b1 : op == JK_RST ? 1'b0 : q;
    endfunction
endpackage

// File: rtl/jk_bank_cell.sv
// jk_bank_cell: single JK flip-flop with asynchronous active-low clear
module jk_bank_cell (
    input  logic clk,
    input  logic clr,
    input  logic J,
    input  logic K,
    output logic Q
);
    import jk_bank_pkg::*;

    always_ff @(posedge clk or negedge clr)
        if (!clr) Q <= 1'b0;
        else      Q <= jk_next(Q, {J, K});
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbitration of two JK commands onto a shared cell bank
module jk_bank_arbiter #(
    parameter int N_BITS = 8,
    parameter int IDX_W  = $clog2(N_BITS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [IDX_W-1:0]  req_idx0,
    input  logic [IDX_W-1:0]  req_idx1,
    output logic [1:0]        req_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_q,
    output logic              rsp_err,
    output logic [N_BITS-1:0] q_bank
);
    import jk_bank_pkg::*;

    state_t             state_q;
    logic               last_grant_q;
    logic               id_q;
    logic [1:0]         op_q;
    logic [IDX_W-1:0]   idx_q;
    logic               winner;
    logic               err;
    logic               cur;
    logic               apply;
    logic [N_BITS-1:0]  j_vec;
    logic [N_BITS-1:0]  k_vec;

    // on contention the requester that did not win last time goes first
    assign winner    = &req_valid ? ~last_grant_q : req_valid[1];
    assign req_ready = (state_q == ST_IDLE && |req_valid) ? {winner, ~winner} : 2'b00;

    assign err   = int'(idx_q) >= N_BITS;
    assign cur   = |(q_bank & (N_BITS'(1) << idx_q));
    assign apply = state_q == ST_APPLY && !err;
    assign j_vec = apply ? N_BITS'(op_q[1]) << idx_q : '0;
    assign k_vec = apply ? N_BITS'(op_q[0]) << idx_q : '0;

    for (genvar i = 0; i < N_BITS; i++) begin : g_cell
        jk_bank_cell u_cell (
            .clk (clk),
            .clr (clr),
            .J   (j_vec[i]),
            .K   (k_vec[i]),
            .Q   (q_bank[i])
        );
    end

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= JK_HOLD;
            idx_q        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_q        <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (|req_valid) begin
                    state_q      <= ST_APPLY;
                    last_grant_q <= winner;
                    id_q         <= winner;
                    op_q         <= winner ? req_op1 : req_op0;
                    idx_q        <= winner ? req_idx1 : req_idx0;
                end
                // response mirrors the value the addressed cell takes on this same edge
                ST_APPLY: begin
                    state_q   <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_q     <= !err && jk_next(cur, op_q);
                    rsp_err   <= err;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed table-driven checks of arbitration, JK ops, range errors and reset
module tb_jk_bank_arbiter;
    import jk_bank_pkg::*;

    typedef struct {
        bit         d;
        bit         r;
        logic [1:0] op;
        logic [2:0] idx;
        bit         q;
        bit         err;
        logic [7:0] bank;
    } vec_t;

    logic       clk, clr;
    logic [1:0] v8, v6;
    logic [1:0] op0, op1;
    logic [2:0] idx0, idx1;
    logic [1:0] rdy8, rdy6;
    logic       rv8, rv6, rid8, rid6, rq8, rq6, re8, re6;
    logic [7:0] bank8;
    logic [5:0] bank6;
    bit         sel;
    logic [1:0] ready_m;
    logic       rv_m, rid_m, rq_m, re_m;
    logic [7:0] bank_m;
    int         checks, errors;
    vec_t       tbl[13];

    jk_bank_arbiter #(.N_BITS(8)) dut (
        .clk(clk), .clr(clr), .req_valid(v8), .req_op0(op0), .req_op1(op1),
        .req_idx0(idx0), .req_idx1(idx1), .req_ready(rdy8), .rsp_valid(rv8),
        .rsp_id(rid8), .rsp_q(rq8), .rsp_err(re8), .q_bank(bank8)
    );

    jk_bank_arbiter #(.N_BITS(6)) dut6 (
        .clk(clk), .clr(clr), .req_valid(v6), .req_op0(op0), .req_op1(op1),
        .req_idx0(idx0), .req_idx1(idx1), .req_ready(rdy6), .rsp_valid(rv6),
        .rsp_id(rid6), .rsp_q(rq6), .rsp_err(re6), .q_bank(bank6)
    );

    always_comb begin
        ready_m = sel ? rdy6 : rdy8;
        rv_m    = sel ? rv6 : rv8;
        rid_m   = sel ? rid6 : rid8;
        rq_m    = sel ? rq6 : rq8;
        re_m    = sel ? re6 : re8;
        bank_m  = sel ? {2'b00, bank6} : bank8;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic drive(input bit d, input bit r, input bit en, input logic [1:0] op, input logic [2:0] idx);
        if (r) begin op1 = op; idx1 = idx; end
        else   begin op0 = op; idx0 = idx; end
        v8 = (!d && en) ? (r ? 2'b10 : 2'b01) : 2'b00;
        v6 = ( d && en) ? (r ? 2'b10 : 2'b01) : 2'b00;
    endtask

    // one single-requester command starting just after a rising edge in IDLE
    task automatic txn(input vec_t v);
        sel = v.d;
        drive(v.d, v.r, 1'b1, v.op, v.idx);
        @(negedge clk);
        chk("ready", ready_m, v.r ? 2'b10 : 2'b01);
        chk("rsp_early", rv_m, 0);
        @(posedge clk); #1;
        drive(v.d, v.r, 1'b0, v.op, v.idx);
        @(negedge clk);
        chk("apply_ready", ready_m, 0);
        chk("apply_rsp", rv_m, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid", rv_m, 1);
        chk("rsp_id", rid_m, v.r);
        chk("rsp_q", rq_m, v.q);
        chk("rsp_err", re_m, v.err);
        chk("q_bank", bank_m, v.bank);
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; errors = 0; sel = 1'b0;
        clr = 1'b1; v8 = 2'b00; v6 = 2'b00;
        op0 = JK_HOLD; op1 = JK_HOLD; idx0 = 3'd0; idx1 = 3'd0;
        tbl[0]  = '{0, 0, JK_SET,  3'd3, 1, 0, 8'h0E};
        tbl[1]  = '{0, 1, JK_TGL,  3'd5, 1, 0, 8'h2E};
        tbl[2]  = '{0, 1, JK_TGL,  3'd5, 0, 0, 8'h0E};
        tbl[3]  = '{0, 1, JK_RST,  3'd5, 0, 0, 8'h0E};
        tbl[4]  = '{0, 1, JK_HOLD, 3'd3, 1, 0, 8'h0E};
        tbl[5]  = '{0, 0, JK_RST,  3'd1, 0, 0, 8'h0C};
        tbl[6]  = '{0, 0, JK_TGL,  3'd7, 1, 0, 8'h8C};
        tbl[7]  = '{0, 1, JK_TGL,  3'd0, 1, 0, 8'h8D};
        tbl[8]  = '{0, 0, JK_HOLD, 3'd6, 0, 0, 8'h8D};
        tbl[9]  = '{1, 0, JK_SET,  3'd5, 1, 0, 8'h20};
        tbl[10] = '{1, 1, JK_SET,  3'd7, 0, 1, 8'h20};
        tbl[11] = '{1, 0, JK_TGL,  3'd6, 0, 1, 8'h20};
        tbl[12] = '{1, 1, JK_TGL,  3'd5, 0, 0, 8'h00};

        #1 clr = 1'b0;
        #2;
        chk("rst_ready", rdy8, 0);
        chk("rst_valid", rv8, 0);
        chk("rst_id", rid8, 0);
        chk("rst_q", rq8, 0);
        chk("rst_err", re8, 0);
        chk("rst_bank", bank8, 0);
        #9 clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_valid", rv8, 0);
        end

        // contention straight out of reset: requester 0 first, then 1 at T+3
        @(posedge clk); #1;
        op0 = JK_SET; idx0 = 3'd1; op1 = JK_SET; idx1 = 3'd2; v8 = 2'b11;
        @(negedge clk); chk("cont_ready0", rdy8, 2'b01);
        @(posedge clk); #1; v8 = 2'b10;
        @(negedge clk); chk("cont_apply_ready", rdy8, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cont_rsp0_valid", rv8, 1);
        chk("cont_rsp0_id", rid8, 0);
        chk("cont_rsp0_q", rq8, 1);
        chk("cont_resp_ready", rdy8, 2'b00);
        chk("cont_bank0", bank8, 8'h02);
        @(posedge clk); #1;
        @(negedge clk); chk("cont_ready1", rdy8, 2'b10);
        @(posedge clk); #1; v8 = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("cont_rsp1_valid", rv8, 1);
        chk("cont_rsp1_id", rid8, 1);
        chk("cont_rsp1_q", rq8, 1);
        chk("cont_bank1", bank8, 8'h06);
        @(posedge clk); #1;
        op0 = JK_HOLD; op1 = JK_HOLD; v8 = 2'b11;
        @(negedge clk); chk("cont_ready2", rdy8, 2'b01);
        @(posedge clk); #1; v8 = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("cont_rsp2_id", rid8, 0);
        chk("cont_rsp2_q", rq8, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) txn(tbl[i]);

        // reset while a set on idx 0 is in APPLY
        sel = 1'b0;
        drive(0, 0, 1'b1, JK_SET, 3'd0);
        @(negedge clk); chk("mid_ready", rdy8, 2'b01);
        @(posedge clk); #1;
        drive(0, 0, 1'b0, JK_SET, 3'd0);
        #2 clr = 1'b0;
        #1;
        chk("mid_rst_bank", bank8, 0);
        chk("mid_rst_valid", rv8, 0);
        chk("mid_rst_q", rq8, 0);
        chk("mid_rst_ready", rdy8, 0);
        @(negedge clk); #2 clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", rv8, 0);
            chk("mid_bank", bank8, 0);
        end
        @(posedge clk); #1;
        txn('{0, 1, JK_SET, 3'd2, 1, 0, 8'h04});
        op0 = JK_HOLD; op1 = JK_HOLD; v8 = 2'b11;
        @(negedge clk); chk("post_rst_arb", rdy8, 2'b01);
        @(posedge clk); #1; v8 = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Shares one bank of `N_BITS` JK flip-flop cells between two command requesters. Each command carries a 2-bit JK operation (hold / reset / set / toggle) and a cell index. A round-robin arbiter picks one command at a time, and a 3-state sequencer drives J/K on the addressed cell for exactly one clock edge, then returns the cell's new value. The block is the control front-end for any design that keeps status or flag bits in JK cells.

## Interface
Parameters:
- `N_BITS`, default 8: number of JK cells in the bank, range 2..256.
- `IDX_W`, default `$clog2(N_BITS)`: width of the index field, derived from `N_BITS`.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `clr`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  2: per-requester command valid; bit r belongs to requester r.
- `req_op0`, `req_op1`  in  2 each: operation {J,K}; 00 hold, 01 reset, 10 set, 11 toggle.
- `req_idx0`, `req_idx1`  in  `IDX_W` each: target cell index.
- `req_ready`  out  2: grant/accept strobe, one-hot or zero.
- `rsp_valid`  out  1: response strobe, 1 cycle.
- `rsp_id`  out  1: requester that owns the response.
- `rsp_q`  out  1: value of the target cell after the operation.
- `rsp_err`  out  1: index was out of range; the command was not applied.
- `q_bank`  out  `N_BITS`: live Q of every cell.

## Operation
- States: IDLE, APPLY, RESP.
- IDLE:
  - If any `req_valid` bit is set, pick a winner and assert `req_ready[winner]` combinationally in that cycle.
  - On the edge, latch the winner's op, index and id, then go to APPLY.
  - A command counts as accepted only on a cycle where both `req_valid[r]` and `req_ready[r]` are 1.
- Arbitration: a `last_grant` register is set to 1 at reset.
  - Only one requester valid: that requester wins.
  - Both valid: the requester ≠ `last_grant` wins.
  - `last_grant` updates only on acceptance.
- APPLY:
  - Drive J/K of cell `idx` with the latched op for one edge. All other cells see J=K=0.
  - If `idx >= N_BITS`, no cell is driven and the error flag is latched.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1, `rsp_id` = latched id, `rsp_q` = `q_bank[idx]` (0 if the index was invalid), `rsp_err` as latched.
  - Go to IDLE.
- Requesters hold valid, op and idx stable until they see ready. No acceptance happens in APPLY or RESP (`req_ready`=0 there).
- Cell behaviour: op 00 keeps Q, 01 gives Q=0, 10 gives Q=1, 11 gives Q=~Q.

## Timing
- Reset (`clr`=0, async):
  - State goes to IDLE, `q_bank`=0, `last_grant`=1.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_q`=0, `rsp_err`=0.
  - Any in-flight command is discarded with no response.
  - `clr` deasserting mid-cycle produces no spurious update before the next edge.
- Latency: acceptance in cycle T; the cell updates at the end of cycle T+1; `rsp_valid` is high in cycle T+2.
- Throughput: one command per 3 cycles. The next acceptance happens at the earliest in T+3.
- `q_bank` reflects the update from cycle T+2 onward, in the same cycle as `rsp_valid`.
- The response and `q_bank` are registered; only `req_ready` is combinational (from state, `req_valid`, `last_grant`).
- A requester that drops `req_valid` before ready: no effect, no state change.

## Structure
- Shared package `jk_bank_pkg`:
  - Op constants `JK_HOLD`=2'b00, `JK_RST`=2'b01, `JK_SET`=2'b10, `JK_TGL`=2'b11.
  - State encoding `ST_IDLE`, `ST_APPLY`, `ST_RESP`.
- Sub-module `jk_bank_cell` (ports Q, J, K, clr, clk; async active-low clear to 0), instantiated `N_BITS` times in a generate loop.
- The arbiter and sequencer live in the top module.

## Test plan
- Reset check: assert `clr`=0 mid-run → all outputs 0 immediately, no `rsp_valid` within 5 cycles after release.
- Single set: requester 0 sends op 10, idx 3 → ready in T, `rsp_valid` in T+2 with id 0, q 1, err 0; `q_bank`=8'h08.
- Contention: both requesters valid from reset with requester 0 {10,idx 1} and requester 1 {10,idx 2} → requester 0 granted first, requester 1 at T+3; `q_bank`=8'h06 after both responses. A further both-valid cycle grants requester 0 again.
- Toggle and reset: requester 1 sends op 11 on idx 5 twice, then op 01 → `rsp_q` sequence 1, 0, 0; hold op 00 returns the unchanged value.
- Out of range: `N_BITS`=6, idx 7 op 10 → `rsp_err`=1, `rsp_q`=0, `q_bank` unchanged.
- Reset mid-operation: drop `clr` during APPLY for a set on idx 0 → no response, `q_bank`=0; the next command after release is accepted normally in IDLE.
